// File: rtl/spi_flash_reader.sv
// Read-only SPI NOR flash controller: fetches one 32-bit little-endian word per
// request using the 0x03 READ command (SPI mode 0).
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 1,
  parameter logic [23:0] FLASH_OFFSET = 24'h200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        sck,
  output logic        sdo,
  input  logic        sdi,
  output logic        cs
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  // IDLE contributes one deselect cycle, so CSHIGH itself lasts 2*CLK_DIV-1 cycles.
  localparam logic [CW-1:0] CS_LAST  = CW'(2 * CLK_DIV - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, CSHIGH} state_t;

  state_t        state, state_n;
  logic          cs_n, sck_n, rdata_valid_n;
  logic [31:0]   shift_out, shift_out_n;
  logic [31:0]   shift_in, shift_in_n;
  logic [31:0]   rdata_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [5:0]    fall_cnt, fall_n;
  logic [CW-1:0] cs_cnt, cs_cnt_n;
  logic [23:0]   flash_addr;

  assign flash_addr = FLASH_OFFSET + (req_addr & ~24'h000003);
  assign req_ready  = (state == IDLE);
  // The out-shift register drains to zero, which also drives sdo low during the in-shift.
  assign sdo        = shift_out[31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cs          <= 1'b1;
      sck         <= 1'b0;
      shift_out   <= '0;
      shift_in    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      div_cnt     <= '0;
      fall_cnt    <= '0;
      cs_cnt      <= '0;
    end else begin
      state       <= state_n;
      cs          <= cs_n;
      sck         <= sck_n;
      shift_out   <= shift_out_n;
      shift_in    <= shift_in_n;
      rdata       <= rdata_n;
      rdata_valid <= rdata_valid_n;
      div_cnt     <= div_n;
      fall_cnt    <= fall_n;
      cs_cnt      <= cs_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    cs_n          = cs;
    sck_n         = sck;
    shift_out_n   = shift_out;
    shift_in_n    = shift_in;
    rdata_n       = rdata;
    rdata_valid_n = 1'b0;
    div_n         = div_cnt;
    fall_n        = fall_cnt;
    cs_cnt_n      = cs_cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_n     = SHIFT;
          cs_n        = 1'b0;
          sck_n       = 1'b0;
          shift_out_n = {8'h03, flash_addr};
          div_n       = '0;
          fall_n      = '0;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          sck_n = ~sck;
          if (!sck) begin
            shift_in_n = {shift_in[30:0], sdi};
          end else begin
            shift_out_n = {shift_out[30:0], 1'b0};
            fall_n      = fall_cnt + 6'd1;
            if (fall_cnt == 6'd63) begin
              cs_n          = 1'b1;
              state_n       = CSHIGH;
              cs_cnt_n      = '0;
              rdata_valid_n = 1'b1;
              // First received byte sits in the top of shift_in; it belongs in rdata[7:0].
              rdata_n = {shift_in[7:0], shift_in[15:8], shift_in[23:16], shift_in[31:24]};
            end
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      CSHIGH: begin
        if (cs_cnt == CS_LAST) state_n = IDLE;
        else                   cs_cnt_n = cs_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: two instances (CLK_DIV 1 and 3), each
// wired to a small behavioural SPI flash that serves the 0x03 READ command.
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid   [2];
  logic [23:0] req_addr    [2];
  logic        req_ready   [2];
  logic [31:0] rdata       [2];
  logic        rdata_valid [2];
  logic        sck [2], sdo [2], sdi [2], cs [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_flash_reader #(.CLK_DIV(1), .FLASH_OFFSET(24'h200000)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rdata(rdata[0]), .rdata_valid(rdata_valid[0]),
    .sck(sck[0]), .sdo(sdo[0]), .sdi(sdi[0]), .cs(cs[0]));

  spi_flash_reader #(.CLK_DIV(3), .FLASH_OFFSET(24'h200000)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rdata(rdata[1]), .rdata_valid(rdata_valid[1]),
    .sck(sck[1]), .sdo(sdo[1]), .sdi(sdi[1]), .cs(cs[1]));

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    case (a)
      24'h200000: return 8'h13;
      24'h200001: return 8'h05;
      24'h200002: return 8'h00;
      24'h200003: return 8'h00;
      24'h200004: return 8'hB7;
      24'h200005: return 8'h02;
      24'h200006: return 8'h01;
      24'h200007: return 8'h00;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  int          bitcnt    [2];
  logic [31:0] cmd_sr    [2];
  logic [31:0] cmd_word  [2];
  int          sdo_bad   [2];
  int          valid_count [2];
  int          viol      [2];
  int          rise_cyc  [2];
  int          fall_cyc  [2];
  int          sck_last  [2];
  int          sck_prev  [2];
  logic        prev_cs   [2];
  logic        prev_sck  [2];

  for (genvar g = 0; g < 2; g++) begin : chan
    int n;
    logic [7:0] b;
    initial begin
      bitcnt[g] = 0; cmd_sr[g] = '0; cmd_word[g] = '0; sdo_bad[g] = 0;
      valid_count[g] = 0; viol[g] = 0; rise_cyc[g] = 0; fall_cyc[g] = 0;
      sck_last[g] = 0; sck_prev[g] = 0; prev_cs[g] = 1'b1; prev_sck[g] = 1'b0;
      sdi[g] = 1'b0;
    end

    always @(negedge cs[g]) bitcnt[g] = 0;

    always @(posedge sck[g]) begin
      if (!cs[g]) begin
        if (bitcnt[g] < 32) begin
          cmd_sr[g] = {cmd_sr[g][30:0], sdo[g]};
          if (bitcnt[g] == 31) cmd_word[g] = cmd_sr[g];
        end else if (sdo[g]) begin
          sdo_bad[g]++;
        end
        bitcnt[g]++;
      end
    end

    always @(negedge sck[g]) begin
      if (!cs[g] && bitcnt[g] >= 32 && bitcnt[g] < 64) begin
        n = bitcnt[g] - 32;
        b = flash_byte(cmd_word[g][23:0] + 24'(n / 8));
        sdi[g] = b[7 - (n % 8)];
      end
    end

    always @(negedge clk) begin
      if (rdata_valid[g]) valid_count[g]++;
      if (rdata_valid[g] && req_ready[g]) viol[g]++;
      if (cs[g] != prev_cs[g] && sck[g]) viol[g]++;
      if (cs[g] && !prev_cs[g]) rise_cyc[g] = cyc;
      if (!cs[g] && prev_cs[g]) fall_cyc[g] = cyc;
      if (sck[g] && !prev_sck[g]) begin
        sck_prev[g] = sck_last[g];
        sck_last[g] = cyc;
      end
      prev_cs[g]  = cs[g];
      prev_sck[g] = sck[g];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event, required one", name);
  endtask

  // Raises req_valid and returns the acceptance edge number, or -1 on timeout.
  task automatic request(input int ch, input logic [23:0] addr, output int acc);
    @(negedge clk);
    req_valid[ch] = 1'b1;
    req_addr[ch]  = addr;
    acc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready[ch]) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) timeout("accept");
  endtask

  task automatic wait_valid(input int ch, output bit got);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdata_valid[ch]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("rdata_valid");
  endtask

  typedef struct {
    int          ch;
    logic [23:0] addr;
    logic [31:0] cmd;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v);
    int acc;
    bit got;
    request(v.ch, v.addr, acc);
    if (acc < 0) begin
      req_valid[v.ch] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[v.ch] = 1'b0;
    wait_valid(v.ch, got);
    if (!got) return;
    check("latency", cyc - acc, v.lat);
    check("rdata", rdata[v.ch], v.data);
    check("cmd_addr", cmd_word[v.ch], v.cmd);
    check("sdo_low_in_shift", sdo_bad[v.ch], 0);
    @(negedge clk);
    check("valid_pulse_width", rdata_valid[v.ch], 0);
    check("rdata_held", rdata[v.ch], v.data);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1);
  end

  initial begin
    int  acc1, acc2, vc;
    bit  got;
    logic [31:0] d1;

    vecs[0] = '{0, 24'h000000, 32'h03200000, 32'h00000513, 128};
    vecs[1] = '{0, 24'h000006, 32'h03200004, 32'h000102B7, 128};
    vecs[2] = '{0, 24'hE00000, 32'h03000000, 32'h59585B5A, 128};
    vecs[3] = '{0, 24'h123457, 32'h03323454, 32'h0D0C0F0E, 128};
    vecs[4] = '{1, 24'h000000, 32'h03200000, 32'h00000513, 384};
    vecs[5] = '{1, 24'h000004, 32'h03200004, 32'h000102B7, 384};

    for (int c = 0; c < 2; c++) begin
      req_valid[c] = 1'b0;
      req_addr[c]  = '0;
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", cs[0], 1);
    check("rst_sck", sck[0], 0);
    check("rst_sdo", sdo[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_valid", rdata_valid[0], 0);
    check("rst_ready", req_ready[0], 1);
    check("rst_cs_div3", cs[1], 1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    check("sck_period_div3", sck_last[1] - sck_prev[1], 6);
    check("sck_period_div1", sck_last[0] - sck_prev[0], 2);

    // Back-to-back: req_valid held, address switched after first acceptance.
    request(0, 24'h000000, acc1);
    if (acc1 >= 0) begin
      @(posedge clk);
      #1 req_addr[0] = 24'h000004;
      acc2 = -1;
      d1 = '0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (rdata_valid[0]) d1 = rdata[0];
        if (req_ready[0]) begin
          acc2 = cyc + 1;
          break;
        end
      end
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      if (acc2 < 0) begin
        timeout("b2b_accept");
      end else begin
        @(negedge clk);
        @(negedge clk);
        check("b2b_spacing", acc2 - acc1, 130);
        check("b2b_cs_high", fall_cyc[0] - rise_cyc[0], 2);
        check("b2b_rdata0", d1, 32'h00000513);
        wait_valid(0, got);
        if (got) begin
          check("b2b_latency1", cyc - acc2, 128);
          check("b2b_rdata1", rdata[0], 32'h000102B7);
          check("b2b_cmd1", cmd_word[0], 32'h03200004);
        end
      end
    end else begin
      req_valid[0] = 1'b0;
    end

    // Reset after the 40th SCK rising edge of a frame.
    request(0, 24'h000000, acc1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!cs[0] && bitcnt[0] == 40) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      timeout("rising_40");
    end else begin
      vc = valid_count[0];
      check("sck_before_reset", sck[0], 1);
      #2 reset = 1'b0;
      #1;
      check("async_cs", cs[0], 1);
      check("async_sck", sck[0], 0);
      check("async_sdo", sdo[0], 0);
      check("async_rdata", rdata[0], 0);
      check("async_ready", req_ready[0], 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (300) @(negedge clk);
      check("no_valid_after_abort", valid_count[0], vc);
      check("idle_after_reset", req_ready[0], 1);
      run_vec(vecs[0]);
    end

    repeat (5) @(negedge clk);
    check("protocol_violations_ch0", viol[0], 0);
    check("protocol_violations_ch1", viol[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Read-only SPI flash controller that fetches 32-bit words from an external serial NOR flash using the standard 0x03 READ command. On the SoC side it accepts word read requests through a valid/ready handshake. It returns each word with a single-cycle valid pulse. On the flash side it drives `sck`, `sdo` and `cs` and samples `sdi`, and it connects directly to the off-chip flash (behavioural `spiflash` model in simulation).

## Interface

Parameters:
- `CLK_DIV`, default 1: SCK half-period in `clk` cycles. Must be ≥1; 0 is illegal.
- `FLASH_OFFSET`, default 24'h200000: byte offset added to every request address. Firmware image base in flash.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `reset`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: read request.
- `req_ready`, output, 1: controller idle and able to accept a request.
- `req_addr`, input, 24: byte address. Bits [1:0] are ignored, so reads are word-aligned.
- `rdata`, output, 32: read word. Held until the next completion.
- `rdata_valid`, output, 1: one-cycle pulse, high when `rdata` is new.
- `sck`, output, 1: SPI clock, mode 0, idle low.
- `sdo`, output, 1: MOSI.
- `sdi`, input, 1: MISO.
- `cs`, output, 1: chip select, active-low, idle high.

## Operation

- States: IDLE, SHIFT, CSHIGH.
- `req_ready` = (state == IDLE), combinationally.
- Handshake: a request is accepted on the edge where `req_valid && req_ready`. `req_addr` is captured at that edge. A requester may hold `req_valid` across busy periods.
- Flash address = (FLASH_OFFSET + {req_addr[23:2], 2'b00}) mod 2^24. The sum wraps within 24 bits.
- Out-shift word: {8'h03, flash_addr[23:0]}, sent MSB first over 32 bits.
- In-shift: 32 bits follow the out-shift. During in-shift `sdo` is driven 0.
- Byte order: the first byte received goes to `rdata[7:0]`, the fourth to `rdata[31:24]` (little-endian). Bits within each byte arrive MSB first.
- SHIFT phase: 64 SCK periods.
  - `sdo` changes only while `sck` is low, on the edge that drives `sck` 0.
  - `sdi` is sampled on the edge that drives `sck` 0→1.
- After the 64th SCK falling edge:
  - `cs` goes high.
  - `rdata` is updated and `rdata_valid` pulses for 1 cycle.
  - State becomes CSHIGH.
- CSHIGH: `cs` stays high for 2*CLK_DIV cycles, then state returns to IDLE. This guarantees minimum CS deselect time between back-to-back requests.
- Reset values: `cs`=1, `sck`=0, `sdo`=0, `rdata`=0, `rdata_valid`=0, state IDLE (so `req_ready`=1).
- Reset asserted mid-transfer:
  - All outputs return immediately (asynchronously) to their reset values.
  - The transfer is abandoned and no `rdata_valid` is produced.
  - After reset deassertion the controller is in IDLE.

## Timing

- Acceptance edge = E0. In the cycle after E0: `cs`=0, `sck`=0, `sdo` = command bit 7 (0).
- `sck` toggles every CLK_DIV cycles. The first rising edge is at E(CLK_DIV).
- The k-th rising edge (k=1..64) is at E((2k-1)*CLK_DIV). The k-th falling edge is at E(2k*CLK_DIV).
- The 64th falling edge is E(128*CLK_DIV). In the cycle after it: `cs`=1, `sck`=0, `rdata_valid`=1.
- Request-to-data latency: 128*CLK_DIV cycles after E0. With CLK_DIV=1 this is 128 cycles.
- `req_ready` returns to 1 at E(130*CLK_DIV).
  - Back-to-back throughput: one word per 130*CLK_DIV cycles.
  - With CLK_DIV=1 a new request can be accepted 130 cycles after the previous one.
- `sck` never glitches. `cs` never falls while `sck`=1, and never rises while `sck`=1.
- `rdata_valid` and `req_ready` are never high in the same cycle.

## Test plan

Bench: `spiflash` model with OFFSET 24'h200000, using bytes at flash 0x200000..0x200007 = 13 05 00 00 B7 02 01 00.

1. Reset, then `req_addr`=0x000000 with CLK_DIV=1.
   - `sdo` carries 0x03, 0x20, 0x00, 0x00.
   - `rdata_valid` is high exactly 128 cycles after acceptance, with `rdata`=0x00000513.
2. `req_addr`=0x000006, which is unaligned.
   - Flash address is 0x200004 and `rdata`=0x000102B7.
3. Two back-to-back requests, 0x0 then 0x4, with `req_valid` held high.
   - The second is accepted exactly 130 cycles after the first.
   - `cs` is high for 2 cycles between frames.
   - Data matches tests 1 and 2.
4. CLK_DIV=3, `req_addr`=0x0.
   - `sck` period is 6 cycles.
   - `rdata_valid` is high 384 cycles after acceptance, with `rdata`=0x00000513.
5. `req_addr`=0xE00000 with FLASH_OFFSET=0x200000.
   - Address wraps: `sdo` address bytes are 0x00, 0x00, 0x00.
6. Assert `reset` after the 40th SCK rising edge.
   - `cs`=1 and `sck`=0 with no clock edge.
   - No `rdata_valid` pulse occurs.
   - A subsequent request to 0x0 returns 0x00000513.
